// File: rtl/dbg_reg_access_pkg.sv
// Shared register-file defines plus debug access op/state encodings.
// The read-next helper is only present when DBG_AUTOINC_EN is defined.
`ifndef DBG_REG_ACCESS_DEFINES
`define DBG_REG_ACCESS_DEFINES
`define RegBus      31:0
`define RegAddrBus  4:0
`define RstEnable   1'b0
`define WriteEnable 1'b1
`define ZeroReg     5'b00000
`define ZeroWord    32'h00000000
`endif

package dbg_reg_access_pkg;

    localparam int unsigned RegW     = 32;
    localparam int unsigned RegAddrW = 5;

    typedef enum logic [1:0] {
        DbgOpNop    = 2'b00,
        DbgOpRead   = 2'b01,
        DbgOpWrite  = 2'b10,
        DbgOpRdNext = 2'b11
    } dbg_op_e;

    typedef enum logic [1:0] {
        DbgIdle   = 2'b00,
        DbgHalt   = 2'b01,
        DbgAccess = 2'b10,
        DbgResp   = 2'b11
    } dbg_state_e;

`ifdef DBG_AUTOINC_EN
    // Next register after a; x0 is never a valid auto-increment target.
    function automatic logic [RegAddrW-1:0] dbg_next_addr(input logic [RegAddrW-1:0] a);
        return (a == RegAddrW'(31)) ? RegAddrW'(1) : RegAddrW'(a + RegAddrW'(1));
    endfunction
`endif

endpackage

// File: rtl/dbg_halt_timer.sv
// Halt-acknowledge timeout counter; saturates at HALT_TIMEOUT.
// expired_c flags the enabled cycle whose increment reaches HALT_TIMEOUT.
module dbg_halt_timer #(
    parameter int unsigned HALT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst == `RstEnable || clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != CNT_W'(HALT_TIMEOUT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = en && (cnt_q == CNT_W'(HALT_TIMEOUT - 1));

endmodule

// File: rtl/dbg_reg_access.sv
// Debug-side initiator for the register file JTAG port: halt core, one access, respond.
// Optional feature macro: DBG_AUTOINC_EN (op 11 = read at last accessed address + 1).
module dbg_reg_access
    import dbg_reg_access_pkg::*;
#(
    parameter int unsigned HALT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [`RegAddrBus] req_addr_i,
    input  logic [`RegBus]    req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [`RegBus]    rsp_data_o,
    output logic              rsp_err_o,
    output logic              halt_req_o,
    input  logic              halted_i,
    output logic              jtag_we_o,
    output logic [`RegAddrBus] jtag_addr_o,
    output logic [`RegBus]    jtag_wdata_o,
    input  logic [`RegBus]    jtag_rdata_i
);

    dbg_state_e           state_q, state_d;
    dbg_op_e              op_q, op_d, req_op_c;
    logic [`RegAddrBus]   addr_q, addr_d;
    logic [`RegBus]       wdata_q, wdata_d;
    logic [`RegBus]       rsp_data_d;
    logic                 rsp_err_d, halt_req_d, jtag_we_d;
    logic [`RegAddrBus]   jtag_addr_d;
    logic [`RegBus]       jtag_wdata_d;
    logic                 accept_c, op_valid_c, timer_en_c, timer_expired_c;
`ifdef DBG_AUTOINC_EN
    logic [`RegAddrBus]   last_addr_q, last_addr_d;
`endif

    assign req_op_c   = dbg_op_e'(req_op_i);
    assign accept_c   = req_valid_i && req_ready_o;
    assign timer_en_c = (state_q == DbgHalt) && !halted_i;

`ifdef DBG_AUTOINC_EN
    assign op_valid_c = (req_op_c != DbgOpNop);
`else
    assign op_valid_c = (req_op_c == DbgOpRead) || (req_op_c == DbgOpWrite);
`endif

    dbg_halt_timer #(
        .HALT_TIMEOUT (HALT_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_halt_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept_c),
        .en        (timer_en_c),
        .expired_c (timer_expired_c)
    );

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_data_d   = rsp_data_o;
        rsp_err_d    = rsp_err_o;
        halt_req_d   = halt_req_o;
        jtag_we_d    = 1'b0;
        jtag_addr_d  = jtag_addr_o;
        jtag_wdata_d = jtag_wdata_o;
`ifdef DBG_AUTOINC_EN
        last_addr_d  = last_addr_q;
`endif
        unique case (state_q)
            DbgIdle: begin
                if (accept_c) begin
                    rsp_data_d = `ZeroWord;
                    op_d       = req_op_c;
                    addr_d     = req_addr_i;
                    wdata_d    = req_data_i;
                    if (op_valid_c) begin
`ifdef DBG_AUTOINC_EN
                        if (req_op_c == DbgOpRdNext) begin
                            addr_d = dbg_next_addr(last_addr_q);
                        end
`endif
                        rsp_err_d  = 1'b0;
                        halt_req_d = 1'b1;
                        state_d    = DbgHalt;
                    end else begin
                        rsp_err_d  = 1'b1;
                        state_d    = DbgResp;
                    end
                end
            end
            DbgHalt: begin
                if (halted_i) begin
                    jtag_addr_d  = addr_q;
                    jtag_wdata_d = wdata_q;
                    if (op_q == DbgOpWrite) begin
                        jtag_we_d = `WriteEnable;
                    end
                    state_d = DbgAccess;
                end else if (timer_expired_c) begin
                    rsp_err_d  = 1'b1;
                    halt_req_d = 1'b0;
                    state_d    = DbgResp;
                end
            end
            DbgAccess: begin
                if (op_q != DbgOpWrite) begin
                    rsp_data_d = jtag_rdata_i;
                end
`ifdef DBG_AUTOINC_EN
                last_addr_d = addr_q;
`endif
                state_d = DbgResp;
            end
            DbgResp: begin
                if (rsp_ready_i) begin
                    halt_req_d = 1'b0;
                    state_d    = DbgIdle;
                end
            end
            default: state_d = DbgIdle;
        endcase
    end

    // State, latches and registered outputs; reset also aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            state_q      <= DbgIdle;
            op_q         <= DbgOpNop;
            addr_q       <= `ZeroReg;
            wdata_q      <= `ZeroWord;
            req_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= `ZeroWord;
            rsp_err_o    <= 1'b0;
            halt_req_o   <= 1'b0;
            jtag_we_o    <= 1'b0;
            jtag_addr_o  <= `ZeroReg;
            jtag_wdata_o <= `ZeroWord;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_o  <= (state_d == DbgIdle);
            rsp_valid_o  <= (state_d == DbgResp);
            rsp_data_o   <= rsp_data_d;
            rsp_err_o    <= rsp_err_d;
            halt_req_o   <= halt_req_d;
            jtag_we_o    <= jtag_we_d;
            jtag_addr_o  <= jtag_addr_d;
            jtag_wdata_o <= jtag_wdata_d;
        end
    end

`ifdef DBG_AUTOINC_EN
    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            last_addr_q <= `ZeroReg;
        end else begin
            last_addr_q <= last_addr_d;
        end
    end
`endif

endmodule

// File: tb/tb_dbg_reg_access.sv
// Bench for dbg_reg_access: directed steps plus random transactions against a transaction-level model.
module tb_dbg_reg_access;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        halt_req_o;
    logic        halted_i;
    logic        jtag_we_o;
    logic [4:0]  jtag_addr_o;
    logic [31:0] jtag_wdata_o;
    logic [31:0] jtag_rdata_i;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] rf   [32];
    logic [31:0] m_rf [32];
    logic [4:0]  m_last;
    logic        rf_init;

    dbg_reg_access #(
        .HALT_TIMEOUT (T),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .halt_req_o   (halt_req_o),
        .halted_i     (halted_i),
        .jtag_we_o    (jtag_we_o),
        .jtag_addr_o  (jtag_addr_o),
        .jtag_wdata_o (jtag_wdata_o),
        .jtag_rdata_i (jtag_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Behavioural register file: x0 reads zero and ignores writes.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (jtag_we_o && jtag_addr_o != 5'd0) begin
            rf[jtag_addr_o] <= jtag_wdata_o;
        end
    end
    assign jtag_rdata_i = (jtag_addr_o == 5'd0) ? 32'd0 : rf[jtag_addr_o];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request from accept to handshake; d = cycles before halted_i rises.
    task automatic do_txn(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data,
                          input int d, input int stall);
        bit          ok, tmo, wr, good;
        logic [4:0]  ea;
        logic [31:0] exp_data, we_a, we_d;
        int          exp_lat, lat, cyc, n, pulses;
        ok = (op == 2'b01) || (op == 2'b10);
`ifdef DBG_AUTOINC_EN
        ok = ok || (op == 2'b11);
        ea = (op == 2'b11) ? 5'((int'(m_last) % 31) + 1) : addr;
`else
        ea = addr;
`endif
        wr       = (op == 2'b10);
        tmo      = ok && (d >= int'(T));
        good     = ok && !tmo;
        exp_lat  = !ok ? 1 : (tmo ? int'(T) + 1 : d + 3);
        exp_data = (good && !wr) ? m_rf[ea] : 32'd0;

        n = 0;
        while (!req_ready_o && n < 32) begin
            tick();
            n++;
        end
        chk("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_data_i  = data;
        tick();
        req_valid_i = 1'b0;
        req_op_i    = 2'($urandom);
        req_addr_i  = 5'($urandom);
        req_data_i  = $urandom;
        chk("halt_req_after_accept", 32'(halt_req_o), 32'(ok));

        lat = 1; cyc = 0; pulses = 0; we_a = '0; we_d = '0;
        while (!rsp_valid_o && lat < 64) begin
            halted_i = (cyc >= d);
            if (jtag_we_o) begin
                pulses++;
                we_a = 32'(jtag_addr_o);
                we_d = jtag_wdata_o;
            end
            tick();
            cyc++;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_err", 32'(rsp_err_o), 32'(!good));
        chk("rsp_data", rsp_data_o, exp_data);
        chk("we_pulses", 32'(pulses), 32'(good && wr));
        chk("we_in_resp", 32'(jtag_we_o), 32'd0);
        chk("halt_req_resp", 32'(halt_req_o), 32'(good));
        if (good && wr) begin
            chk("we_addr", we_a, 32'(ea));
            chk("we_data", we_d, data);
        end
        if (good) chk("jtag_addr", 32'(jtag_addr_o), 32'(ea));

        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", 32'(rsp_valid_o), 32'd1);
            chk("stall_data", rsp_data_o, exp_data);
            chk("stall_ready", 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        halted_i    = 1'b0;
        chk("post_hs_valid", 32'(rsp_valid_o), 32'd0);
        chk("post_hs_halt", 32'(halt_req_o), 32'd0);
        chk("post_hs_ready", 32'(req_ready_o), 32'd1);

        if (good) begin
            if (wr && ea != 5'd0) m_rf[ea] = data;
            m_last = ea;
        end
    endtask

    initial begin
        rst = 1'b0; rf_init = 1'b1;
        req_valid_i = 1'b0; req_op_i = 2'b00; req_addr_i = '0; req_data_i = '0;
        rsp_ready_i = 1'b0; halted_i = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = (i == 0) ? 32'd0 : init_val(i);
        m_last = '0;
        tick();
        tick();
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        chk("rst_err", 32'(rsp_err_o), 32'd0);
        chk("rst_halt", 32'(halt_req_o), 32'd0);
        chk("rst_we", 32'(jtag_we_o), 32'd0);
        chk("rst_addr", 32'(jtag_addr_o), 32'd0);
        chk("rst_wdata", jtag_wdata_o, 32'd0);
        rf_init = 1'b0;
        rst     = 1'b1;
        tick();

        do_txn(2'b10, 5'd5, 32'hDEAD_BEEF, 0, 0);
        do_txn(2'b01, 5'd5, 32'h0, 0, 1);
        do_txn(2'b10, 5'd9, 32'h1234_5678, 10, 0);
        do_txn(2'b00, 5'd3, 32'h0, 0, 0);
        do_txn(2'b01, 5'd5, 32'h0, 0, 10);
        do_txn(2'b10, 5'd0, 32'hFFFF_FFFF, 1, 0);
        do_txn(2'b01, 5'd0, 32'h0, 0, 0);
        do_txn(2'b01, 5'd9, 32'h0, int'(T) - 1, 0);
        do_txn(2'b01, 5'd9, 32'h0, int'(T), 0);
        do_txn(2'b01, 5'd31, 32'h0, 0, 0);
        do_txn(2'b11, 5'd7, 32'h0, 0, 0);
        do_txn(2'b11, 5'd7, 32'h0, 2, 0);

        // Reset while waiting for halt: access aborted, no response.
        req_valid_i = 1'b1; req_op_i = 2'b10; req_addr_i = 5'd12; req_data_i = 32'h5555_AAAA;
        tick();
        req_valid_i = 1'b0;
        halted_i    = 1'b0;
        tick();
        tick();
        chk("mid_halt_req", 32'(halt_req_o), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_last = '0;
        chk("abort_halt", 32'(halt_req_o), 32'd0);
        chk("abort_valid", 32'(rsp_valid_o), 32'd0);
        chk("abort_ready", 32'(req_ready_o), 32'd1);
        chk("abort_we", 32'(jtag_we_o), 32'd0);
        tick();
        chk("abort_no_rsp", 32'(rsp_valid_o), 32'd0);
        do_txn(2'b01, 5'd12, 32'h0, 0, 0);
        do_txn(2'b11, 5'd0, 32'h0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            do_txn(2'($urandom_range(0, 3)), 5'($urandom), $urandom,
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
